// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipe scroller playfield.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    OVER  = 2'd2,
    FLUSH = 2'd3
  } scroll_state_t;

  localparam int unsigned ROWS_DEF  = 16;
  localparam int unsigned COLS_DEF  = 16;
  localparam logic [7:0]  SCORE_MAX = 8'd99;

endpackage

// File: rtl/pipe_spawn_ctrl.sv
// Pending-pipe latch and spacing counter; decides what enters the right edge on each scroll.
module pipe_spawn_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned GAP_MIN = 3
) (
  input  logic            clkM,
  input  logic            reset,
  input  logic            spawn_req,
  input  logic [ROWS-1:0] new_pipe,
  input  logic            spawn_en,
  input  logic            tick,
  input  logic            clear,
  output logic            inject,
  output logic [ROWS-1:0] col_in
);

  localparam int unsigned GW = (GAP_MIN < 1) ? 1 : $clog2(GAP_MIN + 1);

  logic            pending_q, pending_d;
  logic [ROWS-1:0] pend_q, pend_d;
  logic [GW-1:0]   gap_q, gap_d;

  assign inject = tick && pending_q && (gap_q >= GW'(GAP_MIN));
  assign col_in = inject ? pend_q : '0;

  always_comb begin
    pending_d = pending_q;
    pend_d    = pend_q;
    gap_d     = gap_q;
    if (tick) begin
      if (inject) begin
        pending_d = 1'b0;
        gap_d     = '0;
      end else if (gap_q < GW'(GAP_MIN)) begin
        gap_d = gap_q + GW'(1);
      end
    end
    // A request in the consuming cycle re-arms with the new pattern; the old one was used.
    if (spawn_en && spawn_req) begin
      pending_d = 1'b1;
      pend_d    = new_pipe;
    end
    if (clear) begin
      pending_d = 1'b0;
      gap_d     = GW'(GAP_MIN);
    end
  end

  always_ff @(posedge clkM) begin
    if (reset) begin
      pending_q <= 1'b0;
      pend_q    <= '0;
      gap_q     <= GW'(GAP_MIN);
    end else begin
      pending_q <= pending_d;
      pend_q    <= pend_d;
      gap_q     <= gap_d;
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Full-playfield pipe shift buffer with play/over/flush FSM.
// Optional pipes-passed score counter enabled by PIPE_SCORE_EN.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned COLS    = COLS_DEF,
  parameter int unsigned GAP_MIN = 3
) (
  input  logic                 clkM,
  input  logic                 reset,
  input  logic                 scrollTick,
  input  logic                 start,
  input  logic                 gameover,
  input  logic                 spawnReq,
  input  logic [ROWS-1:0]      newPipe,
  output logic [ROWS*COLS-1:0] field,
  output logic [ROWS-1:0]      leftCol,
  output logic [1:0]           state,
  output logic                 passed,
  output logic                 spawnAck,
  output logic [7:0]           score
);

  localparam int unsigned FW = (COLS > 1) ? $clog2(COLS) : 1;

  scroll_state_t         state_q, state_d;
  logic [ROWS*COLS-1:0]  field_q, field_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic                  passed_q, passed_d;
  logic                  ack_q, ack_d;
  logic                  shift_run, flush_exit, inject;
  logic [ROWS-1:0]       col_in;

  pipe_spawn_ctrl #(
    .ROWS    (ROWS),
    .GAP_MIN (GAP_MIN)
  ) u_spawn (
    .clkM      (clkM),
    .reset     (reset),
    .spawn_req (spawnReq),
    .new_pipe  (newPipe),
    .spawn_en  (state_q != FLUSH),
    .tick      (shift_run),
    .clear     (flush_exit),
    .inject    (inject),
    .col_in    (col_in)
  );

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    flush_d    = flush_q;
    passed_d   = 1'b0;
    ack_d      = 1'b0;
    shift_run  = 1'b0;
    flush_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        field_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        // gameover wins over a coincident tick: the field freezes as it was.
        if (gameover) begin
          state_d = OVER;
        end else if (scrollTick) begin
          shift_run = 1'b1;
          field_d   = {col_in, field_q[ROWS*COLS-1:ROWS]};
          passed_d  = |field_q[ROWS-1:0];
          ack_d     = inject;
        end
      end
      OVER: begin
        if (start && !gameover) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end
      FLUSH: begin
        field_d = {{ROWS{1'b0}}, field_q[ROWS*COLS-1:ROWS]};
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(COLS - 1)) begin
          state_d    = IDLE;
          flush_d    = '0;
          flush_exit = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clkM) begin
    if (reset) begin
      state_q  <= IDLE;
      field_q  <= '0;
      flush_q  <= '0;
      passed_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      flush_q  <= flush_d;
      passed_q <= passed_d;
      ack_q    <= ack_d;
    end
  end

`ifdef PIPE_SCORE_EN
  logic [7:0] score_q;

  always_ff @(posedge clkM) begin
    if (reset) begin
      score_q <= '0;
    end else if (state_q == IDLE && state_d == RUN) begin
      score_q <= '0;
    end else if (passed_d && score_q < SCORE_MAX) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

  assign field    = field_q;
  assign leftCol  = field_q[ROWS-1:0];
  assign state    = state_q;
  assign passed   = passed_q;
  assign spawnAck = ack_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized and directed bench for pipe_scroller with a queue-based playfield model
// and a per-cycle scoreboard.
module tb_pipe_scroller;
  import pipe_pkg::*;

  localparam int ROWS    = 16;
  localparam int COLS    = 16;
  localparam int GAP_MIN = 3;

  logic                 clkM = 1'b0;
  logic                 reset = 1'b1;
  logic                 scrollTick = 1'b0;
  logic                 start = 1'b0;
  logic                 gameover = 1'b0;
  logic                 spawnReq = 1'b0;
  logic [ROWS-1:0]      newPipe = '0;
  logic [ROWS*COLS-1:0] field;
  logic [ROWS-1:0]      leftCol;
  logic [1:0]           state;
  logic                 passed;
  logic                 spawnAck;
  logic [7:0]           score;

  pipe_scroller #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .GAP_MIN (GAP_MIN)
  ) dut (
    .clkM       (clkM),
    .reset      (reset),
    .scrollTick (scrollTick),
    .start      (start),
    .gameover   (gameover),
    .spawnReq   (spawnReq),
    .newPipe    (newPipe),
    .field      (field),
    .leftCol    (leftCol),
    .state      (state),
    .passed     (passed),
    .spawnAck   (spawnAck),
    .score      (score)
  );

  always #5 clkM = ~clkM;

  typedef struct {
    logic [ROWS*COLS-1:0] field;
    logic                 passed;
    logic                 ack;
    logic [1:0]           state;
    logic [7:0]           score;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: playfield as a queue of columns, front = leftmost.
  logic [ROWS-1:0] mq[$];
  scroll_state_t   mstate;
  bit              mpending;
  logic [ROWS-1:0] mpend;
  int              mgap, mflush, mscore;

  task automatic chk(input string nm, input logic [ROWS*COLS-1:0] act, input logic [ROWS*COLS-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h required %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clkM) begin
    if (exq.size() > 0) begin
      mon_e = exq.pop_front();
      chk("field", field, mon_e.field);
      chk("leftCol", {{(ROWS*COLS-ROWS){1'b0}}, leftCol},
          {{(ROWS*COLS-ROWS){1'b0}}, mon_e.field[ROWS-1:0]});
      chk("state", {{(ROWS*COLS-2){1'b0}}, state}, {{(ROWS*COLS-2){1'b0}}, mon_e.state});
      chk("passed", {{(ROWS*COLS-1){1'b0}}, passed}, {{(ROWS*COLS-1){1'b0}}, mon_e.passed});
      chk("spawnAck", {{(ROWS*COLS-1){1'b0}}, spawnAck}, {{(ROWS*COLS-1){1'b0}}, mon_e.ack});
      chk("score", {{(ROWS*COLS-8){1'b0}}, score}, {{(ROWS*COLS-8){1'b0}}, mon_e.score});
    end
  end

  task automatic model_step();
    logic [ROWS-1:0] old0;
    scroll_state_t   s0;
    bit              p, a;
    exp_t            e;
    p = 0;
    a = 0;
    if (reset) begin
      mstate = IDLE;
      mq.delete();
      repeat (COLS) mq.push_back('0);
      mpending = 0;
      mpend    = '0;
      mgap     = GAP_MIN;
      mflush   = 0;
      mscore   = 0;
    end else begin
      s0 = mstate;
      case (s0)
        IDLE: if (start) begin
          mstate = RUN;
          mscore = 0;
        end
        RUN: begin
          if (gameover) begin
            mstate = OVER;
          end else if (scrollTick) begin
            old0 = mq.pop_front();
            if (mpending && mgap >= GAP_MIN) begin
              mq.push_back(mpend);
              mpending = 0;
              mgap     = 0;
              a        = 1;
            end else begin
              mq.push_back('0);
              if (mgap < GAP_MIN) mgap++;
            end
            if (old0 != '0) begin
              p = 1;
`ifdef PIPE_SCORE_EN
              if (mscore < 99) mscore++;
`endif
            end
          end
        end
        OVER: if (start && !gameover) begin
          mstate = FLUSH;
          mflush = 0;
        end
        FLUSH: begin
          void'(mq.pop_front());
          mq.push_back('0);
          if (mflush == COLS - 1) begin
            mstate   = IDLE;
            mpending = 0;
            mgap     = GAP_MIN;
          end else begin
            mflush++;
          end
        end
      endcase
      if (spawnReq && s0 != FLUSH) begin
        mpending = 1;
        mpend    = newPipe;
      end
    end
    for (int c = 0; c < COLS; c++) e.field[c*ROWS +: ROWS] = mq[c];
    e.passed = p;
    e.ack    = a;
    e.state  = mstate;
    e.score  = 8'(mscore);
    exq.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic st, input logic go, input logic tk,
                       input logic sr, input logic [ROWS-1:0] np);
    @(negedge clkM);
    #1;
    reset      = rst;
    start      = st;
    gameover   = go;
    scrollTick = tk;
    spawnReq   = sr;
    newPipe    = np;
    model_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, '0);
      drive(0, 0, 0, 1, 0, '0);
    end
  endtask

  initial begin
    // Reset and first pipe lands immediately.
    repeat (3) drive(1, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 1, 16'hF0FF);
    drive(0, 0, 0, 1, 0, '0);
    // Gap enforcement: request before every tick.
    ticks(4);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 16'(16'h1111 * (i + 1)));
      drive(0, 0, 0, 1, 0, '0);
    end
    // Clear the field, then a single pipe traverses and leaves.
    ticks(20);
    drive(0, 0, 0, 0, 1, 16'h0F0F);
    drive(0, 0, 0, 1, 0, '0);
    ticks(16);
    // Pipe at column 8, then gameover coincident with a tick.
    drive(0, 0, 0, 0, 1, 16'hA5A5);
    drive(0, 0, 0, 1, 0, '0);
    ticks(7);
    drive(0, 0, 1, 1, 0, '0);
    for (int i = 0; i < 20; i++) drive(0, 0, i[0], 1, 0, '0);
    drive(0, 1, 1, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    // Flush ignores ticks, spawns and gameover.
    for (int i = 0; i < 18; i++) drive(0, 0, i[1], 1, 1, 16'hFFFF);
    // Long run for score saturation.
    drive(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 500; i++) drive(0, 0, 0, 1, 1, 16'($urandom_range(1, 16'hFFFF)));
    drive(0, 0, 1, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    repeat (18) drive(0, 0, 0, 0, 0, '0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
    end
    @(negedge clkM);
    @(negedge clkM);
    #2;
    chk("drain", (ROWS*COLS)'(exq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Full-playfield pipe buffer for the Flappy Bird LED matrix: holds all COLS columns of ROWS-bit pipe patterns and scrolls them left one column per scroll tick.
- Injects new pipe columns at the right edge with enforced minimum spacing, and detects pipes leaving the left edge.
- On gameover, freezes the field; on restart, flushes it.
- Replaces per-column shifter instances; feeds the collision checker and the display driver.

Parameters:
- ROWS, 16, bits per column (matrix height)
- COLS, 16, number of columns held (matrix width)
- GAP_MIN, 3, minimum number of empty columns injected between two pipe columns

Ports:
- clkM  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; sampled on posedge clkM
- scrollTick  in  1  one-clkM-cycle enable pulse; one scroll step per pulse
- start  in  1  level; begins or restarts play
- gameover  in  1  level from collision logic
- spawnReq  in  1  one-cycle pulse requesting a new pipe column
- newPipe  in  ROWS  pipe pattern, sampled in the cycle spawnReq=1
- field  out  ROWS*COLS  column c at bits [c*ROWS +: ROWS]; c=0 is leftmost
- leftCol  out  ROWS  equals column 0 of field
- state  out  2  current FSM state (encoding from package)
- passed  out  1  one-cycle pulse: a non-zero column shifted out of column 0
- spawnAck  out  1  one-cycle pulse: the pending pipe was written into column COLS-1
- score  out  8  pipes passed (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high. All outputs are 0; state=IDLE; pending=0; pendPipe=0; gapCnt=GAP_MIN; flushCnt=0.
- Priority within a cycle: reset > gameover > start > scrollTick.
- IDLE:
  - field held at 0.
  - start=1 -> RUN next cycle.
- RUN, on scrollTick=1:
  - col[i] <= col[i+1] for i in 0..COLS-2.
  - If pending=1 and gapCnt>=GAP_MIN: col[COLS-1] <= pendPipe; pending <= 0; gapCnt <= 0; spawnAck=1 in that cycle.
  - Otherwise: col[COLS-1] <= 0; gapCnt <= gapCnt+1, saturating at GAP_MIN.
  - passed=1 in the same cycle if the old col[0] != 0.
- Spawn latch:
  - spawnReq=1 in any state except FLUSH sets pending=1 and pendPipe=newPipe.
  - A second request while pending overwrites pendPipe (latest wins).
  - spawnReq coincident with consumption: consumption uses the old pendPipe; the new request re-arms pending.
- RUN, gameover=1 -> OVER next cycle. No shift occurs in that cycle, even if scrollTick=1.
- OVER:
  - field frozen; passed and spawnAck held at 0.
  - start=1 with gameover=0 -> FLUSH, flushCnt=0.
  - start=1 with gameover=1 stays in OVER.
- FLUSH:
  - Every clkM cycle, regardless of scrollTick: shift left inserting 0; flushCnt++.
  - After COLS shifts (flushCnt==COLS-1 on the final shift) -> IDLE.
  - pending and gapCnt reset to 0 / GAP_MIN on exit.
  - passed never asserts in FLUSH.
- gameover=1 in IDLE or FLUSH is ignored.
- Latency: field updates exactly one clkM edge after the qualifying scrollTick.
- passed and spawnAck are registered alongside the shift.

Optional Feature:
- Macro: PIPE_SCORE_EN.
- Defined:
  - score increments by 1 on each passed pulse, saturating at 8'd99.
  - Cleared to 0 on reset and on the IDLE->RUN transition.
  - Held in OVER and FLUSH.
- Undefined: score is driven constant 0; no counter is synthesised. Port list is unchanged.

Decomposition:
- Package pipe_pkg:
  - scroll_state_t enum {IDLE=2'd0, RUN=2'd1, OVER=2'd2, FLUSH=2'd3}
  - ROWS_DEF=16, COLS_DEF=16, SCORE_MAX=8'd99
- One sub-module, pipe_spawn_ctrl: owns pending, pendPipe and gapCnt, and decides inject-vs-zero per tick.
- The shift array and FSM stay in the top module.

Test Plan:
- Reset 3 cycles, then start, spawnReq with newPipe=16'hF0FF, then 1 tick -> col15=16'hF0FF, spawnAck=1, state=RUN.
- GAP_MIN=3: spawnReq before each of 5 consecutive ticks -> pipes land only in ticks 1 and 5; col15=0 on ticks 2-4.
- Single pipe 16'h0F0F, then 16 further ticks -> passed pulses exactly once, on the tick where col0 held 16'h0F0F; field all 0 afterwards.
- gameover coincident with scrollTick while a pipe is at col8 -> no shift, state=OVER; field unchanged for 20 ticks.
- In OVER, assert start -> FLUSH for exactly 16 cycles, field=0, then state=IDLE; passed stays 0 throughout.
- PIPE_SCORE_EN defined, 100 pipes passed -> score saturates at 99. Macro undefined -> score stays 0.
